montgomery_reduce_pipe: RTL and testbench



---
 rtl/mont_pkg.sv | 16 +
 rtl/mont_reduce_lane.sv | 84 ++++++++
 rtl/montgomery_reduce_pipe.sv | 81 ++++++++
 tb/tb_montgomery_reduce_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared constants and helpers for the Montgomery reduction pipeline.
// Kyber defaults: q = 3329, R = 2^16.
package mont_pkg;

  localparam int unsigned DW_DEFAULT = 16;
  localparam int          Q_KYBER    = 3329;
  localparam int          QINV_KYBER = -3327;
  // R^2 mod q, used to convert coefficients into the Montgomery domain
  localparam int          R2_MOD_Q   = 1353;

  // Low bit index of lane 'lane' in a bus of 'width'-bit lanes
  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/mont_reduce_lane.sv
// Per-lane Montgomery reduction datapath: stage registers loaded by the top-level enables.
// With MONT_CANONICAL_EN defined, a fourth stage maps the result into [0, Q).
module mont_reduce_lane
  import mont_pkg::*;
#(
  parameter int unsigned DW   = DW_DEFAULT,
  parameter int          Q    = Q_KYBER,
  parameter int          QINV = QINV_KYBER
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            ld_s1,
  input  logic            ld_s2,
  input  logic            ld_s3,
`ifdef MONT_CANONICAL_EN
  input  logic            ld_s4,
`endif
  input  logic [2*DW-1:0] a,
  output logic [DW-1:0]   r
);

  localparam int unsigned AW = 2 * DW;
  localparam int unsigned PW = 2 * DW + 1;
  localparam logic [DW-1:0]        QINV_U = DW'(QINV);
  localparam logic [DW-1:0]        Q_D    = DW'(Q);
  localparam logic signed [PW-1:0] Q_P    = PW'(Q);

  logic [AW-1:0] s1_a, s2_a, s2_p;
  logic [DW-1:0] s1_t, s3_r;

  logic [DW-1:0]        t_c;
  logic signed [PW-1:0] t_ext_c, p_c, diff_c;
  logic [DW-1:0]        r_c;

  // Only the low DW bits of a*QINV matter, so a DW x DW product suffices
  assign t_c     = a[DW-1:0] * QINV_U;
  assign t_ext_c = PW'($signed(s1_t));
  assign p_c     = t_ext_c * Q_P;
  // Low DW bits of diff are zero by construction; the shift is exact
  assign diff_c  = PW'($signed(s2_a)) - PW'($signed(s2_p));
  assign r_c     = DW'(diff_c >>> DW);

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      s1_a <= '0;
      s1_t <= '0;
      s2_a <= '0;
      s2_p <= '0;
      s3_r <= '0;
    end else begin
      if (ld_s1) begin
        s1_a <= a;
        s1_t <= t_c;
      end
      if (ld_s2) begin
        s2_a <= s1_a;
        s2_p <= AW'(p_c);
      end
      if (ld_s3) begin
        s3_r <= r_c;
      end
    end
  end

`ifdef MONT_CANONICAL_EN
  logic [DW-1:0] s4_r;
  logic [DW-1:0] r4_c;

  assign r4_c = s3_r[DW-1] ? (s3_r + Q_D) : s3_r;

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      s4_r <= '0;
    end else if (ld_s4) begin
      s4_r <= r4_c;
    end
  end

  assign r = s4_r;
`else
  assign r = s3_r;
`endif

endmodule

// File: rtl/montgomery_reduce_pipe.sv
// Multi-lane pipelined Montgomery reduction with valid/ready backpressure.
// Define MONT_CANONICAL_EN to add a canonical-range stage (latency 4 instead of 3).
module montgomery_reduce_pipe
  import mont_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned DW    = DW_DEFAULT,
  parameter int          Q     = Q_KYBER,
  parameter int          QINV  = QINV_KYBER
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*2*DW-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*DW-1:0]   out_data
);

  logic advance_c;
  logic v1, v2, v3;
  logic ld_s1_c, ld_s2_c, ld_s3_c;

  // Whole pipe moves together whenever the output slot is free or draining
  assign advance_c = !out_valid || out_ready;
  assign in_ready  = advance_c;
  assign ld_s1_c   = advance_c && in_valid;
  assign ld_s2_c   = advance_c && v1;
  assign ld_s3_c   = advance_c && v2;

`ifdef MONT_CANONICAL_EN
  logic v4;
  logic ld_s4_c;

  assign ld_s4_c   = advance_c && v3;
  assign out_valid = v4;

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      v4 <= 1'b0;
    end else if (advance_c) begin
      v4 <= v3;
    end
  end
`else
  assign out_valid = v3;
`endif

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (advance_c) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
    mont_reduce_lane #(
      .DW   (DW),
      .Q    (Q),
      .QINV (QINV)
    ) u_lane (
      .clk   (clk),
      .srst  (srst),
      .ld_s1 (ld_s1_c),
      .ld_s2 (ld_s2_c),
      .ld_s3 (ld_s3_c),
`ifdef MONT_CANONICAL_EN
      .ld_s4 (ld_s4_c),
`endif
      .a     (in_data[lane_lo(i, 2*DW) +: 2*DW]),
      .r     (out_data[lane_lo(i, DW) +: DW])
    );
  end

endmodule

// File: tb/tb_montgomery_reduce_pipe.sv
// Directed self-checking bench for montgomery_reduce_pipe (2-lane and 4-lane instances).
module tb_montgomery_reduce_pipe;

`ifdef MONT_CANONICAL_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic         clk = 1'b0;
  logic         srst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [63:0]  in_data;
  logic [31:0]  out_data;
  logic         in_valid4, in_ready4, out_valid4, out_ready4;
  logic [127:0] in_data4;
  logic [63:0]  out_data4;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  montgomery_reduce_pipe #(.LANES(2)) u_dut (
    .clk(clk), .srst(srst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  montgomery_reduce_pipe #(.LANES(4)) u_dut4 (
    .clk(clk), .srst(srst), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4)
  );

  // Reference: Montgomery reduction by the textbook formula, optional canonical fold
  function automatic longint mref(input longint a);
    longint lo, t, d, r;
    lo = ((a % 65536) + 65536) % 65536;
    t  = ((lo * 3327) % 65536 + 65536) % 65536;
    t  = (65536 - t) % 65536;
    if (t >= 32768) t = t - 65536;
    d  = a - t * 3329;
    r  = d / 65536;
`ifdef MONT_CANONICAL_EN
    if (r < 0) r = r + 3329;
`endif
    return r;
  endfunction

  function automatic logic [15:0] w16(input longint x);
    return x[15:0];
  endfunction

  function automatic longint rnd_a();
    return longint'($urandom_range(218169340, 0)) - 64'sd109084670;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    srst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; in_data4 = '0;
    tick(); tick();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
    total++; if (out_data !== 32'd0) $display("FAIL reset_out_data got=%h exp=0", out_data); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passed++;
    total++; if (out_valid4 !== 1'b0) $display("FAIL reset_out_valid4 got=%b exp=0", out_valid4); else passed++;
    srst = 1'b0;
    tick();
  endtask

  task automatic test_known_vectors();
    longint kv_a[5] = '{1, -1, 3329, 65536, 0};
`ifdef MONT_CANONICAL_EN
    longint kv_r[5] = '{169, 3160, 0, 1, 0};
`else
    longint kv_r[5] = '{169, -169, 0, 1, 0};
`endif
    int n;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data  = {32'd0, 32'(kv_a[k])};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin tick(); n++; end
      total++; if (n != LAT) $display("FAIL known_latency a=%0d got=%0d exp=%0d", kv_a[k], n, LAT); else passed++;
      total++; if (out_data[15:0] !== w16(kv_r[k]))
        $display("FAIL known_lane0 a=%0d got=%0d exp=%0d", kv_a[k], $signed(out_data[15:0]), kv_r[k]); else passed++;
      total++; if (out_data[31:16] !== 16'd0)
        $display("FAIL known_lane1 a=0 got=%h exp=0", out_data[31:16]); else passed++;
      tick();
    end
  endtask

  task automatic test_stream();
    localparam int N = 1000;
    longint a_q0[$], a_q1[$];
    longint a0, a1, ea0, ea1, r0;
    int got = 0, first = -1, last = -1;
    out_ready = 1'b1;
    for (int c = 0; c < N + 40 && got < N; c++) begin
      if (out_valid) begin
        ea0 = a_q0.pop_front();
        ea1 = a_q1.pop_front();
        total++; if (out_data[15:0] !== w16(mref(ea0)))
          $display("FAIL stream_lane0 a=%0d got=%0d exp=%0d", ea0, $signed(out_data[15:0]), mref(ea0)); else passed++;
        total++; if (out_data[31:16] !== w16(mref(ea1)))
          $display("FAIL stream_lane1 a=%0d got=%0d exp=%0d", ea1, $signed(out_data[31:16]), mref(ea1)); else passed++;
        r0 = longint'($signed(out_data[15:0]));
        total++; if (((r0 - ea0 * 169) % 3329) != 0)
          $display("FAIL stream_congruence a=%0d got=%0d exp=a*169 mod 3329", ea0, r0); else passed++;
        got++;
        if (first < 0) first = c;
        last = c;
      end
      if (c < N) begin
        a0 = rnd_a(); a1 = rnd_a();
        in_data  = {32'(a1), 32'(a0)};
        in_valid = 1'b1;
        a_q0.push_back(a0); a_q1.push_back(a1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    total++; if (got != N) $display("FAIL stream_count got=%0d exp=%0d", got, N); else passed++;
    total++; if (last - first + 1 != N) $display("FAIL stream_throughput got=%0d cycles exp=%0d", last - first + 1, N); else passed++;
  endtask

  task automatic test_backpressure();
    longint b0[3] = '{1, -1, 65536};
    longint b1[3] = '{3329, 0, 1};
    longint q0[$], q1[$];
    longint e0, e1;
    logic [31:0] held;
    int sent = 0, got = 0;
    tick();
    out_ready = 1'b0;
    for (int g = 0; g < 20 && sent < 3; g++) begin
      in_data  = {32'(b1[sent]), 32'(b0[sent])};
      in_valid = 1'b1;
      if (in_ready) begin
        q0.push_back(b0[sent]); q1.push_back(b1[sent]);
        sent++;
      end
      tick();
    end
    in_valid = 1'b0;
    total++; if (sent != 3) $display("FAIL bp_sent got=%0d exp=3", sent); else passed++;
    held = {w16(mref(b1[0])), w16(mref(b0[0]))};
    for (int i = 0; i < 10; i++) begin
      if (LAT == 4 && i == 0) tick();
      total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); else passed++;
      total++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", i, out_valid); else passed++;
      total++; if (out_data !== held) $display("FAIL bp_hold cyc=%0d got=%h exp=%h", i, out_data, held); else passed++;
      tick();
    end
    out_ready = 1'b1;
    for (int g = 0; g < 20 && got < 3; g++) begin
      if (out_valid) begin
        e0 = q0.pop_front(); e1 = q1.pop_front();
        total++; if (out_data !== {w16(mref(e1)), w16(mref(e0))})
          $display("FAIL bp_order idx=%0d got=%h exp=%h", got, out_data, {w16(mref(e1)), w16(mref(e0))}); else passed++;
        got++;
      end
      tick();
    end
    total++; if (got != 3) $display("FAIL bp_drain_count got=%0d exp=3", got); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL bp_no_duplicate got=%b exp=0", out_valid); else passed++;
  endtask

  task automatic test_reset_midflight();
    int n;
    out_ready = 1'b0;
    in_data = {32'd0, 32'd1};           in_valid = 1'b1; tick();
    in_data = {32'd0, 32'hFFFF_FFFF};   in_valid = 1'b1; tick();
    in_valid = 1'b0;
    for (int i = 0; i < LAT - 2; i++) tick();
    total++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid got=%b exp=1", out_valid); else passed++;
    #2 srst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL mid_async_valid got=%b exp=0", out_valid); else passed++;
    total++; if (out_data !== 32'd0) $display("FAIL mid_async_data got=%h exp=0", out_data); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL mid_async_in_ready got=%b exp=1", in_ready); else passed++;
    #1 srst = 1'b0;
    tick();
    out_ready = 1'b1;
    in_data = {32'd0, 32'd1}; in_valid = 1'b1; tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin tick(); n++; end
    total++; if (n != LAT) $display("FAIL mid_after_latency got=%0d exp=%0d", n, LAT); else passed++;
    total++; if (out_data[15:0] !== 16'd169) $display("FAIL mid_after_data got=%0d exp=169", out_data[15:0]); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL mid_no_stale got=%b exp=0", out_valid); else passed++;
  endtask

  task automatic test_lanes4();
    longint va[2][4] = '{'{1, -1, 3329, 65536}, '{65536, 3329, -1, 1}};
`ifdef MONT_CANONICAL_EN
    longint vr[2][4] = '{'{169, 3160, 0, 1}, '{1, 0, 3160, 169}};
`else
    longint vr[2][4] = '{'{169, -169, 0, 1}, '{1, 0, -169, 169}};
`endif
    int n;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 4; i++) in_data4[i*32 +: 32] = 32'(va[b][i]);
      in_valid4 = 1'b1;
      tick();
      in_valid4 = 1'b0;
      n = 1;
      while (!out_valid4 && n < 20) begin tick(); n++; end
      total++; if (n != LAT) $display("FAIL lanes4_latency beat=%0d got=%0d exp=%0d", b, n, LAT); else passed++;
      for (int i = 0; i < 4; i++) begin
        total++; if (out_data4[i*16 +: 16] !== w16(vr[b][i]))
          $display("FAIL lanes4_lane%0d beat=%0d got=%0d exp=%0d", i, b, $signed(out_data4[i*16 +: 16]), vr[b][i]); else passed++;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_stream();
    test_backpressure();
    test_reset_midflight();
    test_lanes4();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
